// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control FSM for the multi-cycle datapath (one ALU,
// one unified memory port, register file, PC). Walks each instruction
// through FETCH/DECODE/execute/write-back states, stalls on MemReady,
// counts retired instructions, and flags illegal opcodes and memory timeouts.
//
// Ports:
//   Clk, Rst             clock (rising edge), synchronous active-high reset
//   Opcode, Funct        IR[31:26], IR[5:0]; Opcode valid from DECODE onward
//   Zero                 ALU zero flag (same cycle)
//   MemReady             memory completes the current access this cycle
//   PCEn..PCSource       datapath mux selects / write enables
//   State                current state code (debug)
//   InstrCount           retired instruction counter (wraps)
//   IllegalOp, MemFault  sticky error flags, cleared only by Rst
module multicycle_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount,
  output logic             IllegalOp,
  output logic             MemFault
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADDR = 4'd2, S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC    = 4'd6, S_RWB    = 4'd7,
    S_BRANCH  = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX  = 4'd10, S_ADDIWB = 4'd11,
    S_JR      = 4'd12
  } state_e;

  localparam bit TO_EN  = (TIMEOUT > 0);
  // Counter only ever holds 0..TIMEOUT-1: the abort fires on the cycle
  // that would make it TIMEOUT.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               illegal_q, illegal_d;
  logic               fault_q, fault_d;
  logic               mem_wait, time_up, retire;

  assign mem_wait = (state_q inside {S_FETCH, S_MEMRD, S_MEMWR}) && !MemReady;
  // MemReady wins over a simultaneous timeout because mem_wait requires !MemReady.
  assign time_up  = TO_EN && mem_wait && (wait_q == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (MemReady)     state_d = S_DECODE;
        else if (time_up) fault_d = 1'b1;  // stay in FETCH, PC untouched
      end
      S_DECODE: begin
        case (Opcode)
          6'b100011, 6'b101011: state_d = S_MEMADDR;
          6'b000000:            state_d = (Funct == 6'b001000) ? S_JR : S_EXEC;
          6'b000100, 6'b000101: state_d = S_BRANCH;
          6'b000010:            state_d = S_JUMP;
          6'b001000:            state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADDR: state_d = (Opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (MemReady) state_d = S_MEMWB;
        else if (time_up) begin
          state_d = S_FETCH;
          fault_d = 1'b1;
        end
      end
      S_MEMWR: begin
        if (MemReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (time_up) begin
          state_d = S_FETCH;
          fault_d = 1'b1;
        end
      end
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_JR, S_ADDIWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Any state change or a non-waiting cycle clears the wait counter.
    wait_d  = (TO_EN && mem_wait && !time_up) ? wait_q + 1'b1 : '0;
    count_d = retire ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  // Moore decode of the registered state; PCEn/IRWrite additionally
  // qualified by MemReady / Zero. Everything is held low during Rst.
  always_comb begin
    PCEn     = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'b00;
    if (!Rst) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemReady;
          PCEn    = MemReady;
        end
        S_DECODE:  ALUSrcB = 2'b11;
        S_MEMADDR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        S_MEMRD:   begin MemRead = 1'b1; IorD = 1'b1; end
        S_MEMWB:   begin RegWrite = 1'b1; MemtoReg = 1'b1; end
        S_MEMWR:   begin MemWrite = 1'b1; IorD = 1'b1; end
        S_EXEC:    begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
        S_RWB:     begin RegDst = 1'b1; RegWrite = 1'b1; end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b01;
          PCSource = 2'b01;
          if (Opcode == 6'b000100)      PCEn = Zero;
          else if (Opcode == 6'b000101) PCEn = !Zero;
        end
        S_JUMP:   begin PCSource = 2'b10; PCEn = 1'b1; end
        S_JR:     begin PCSource = 2'b11; PCEn = 1'b1; end
        S_ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        S_ADDIWB: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign State      = state_q;
  assign InstrCount = count_q;
  assign IllegalOp  = illegal_q;
  assign MemFault   = fault_q;

endmodule
